// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit with architectural HI/LO registers.
// The full result is computed combinationally when a start is accepted and
// parked in pending registers. A down-counter then models the multi-cycle
// latency before the result is committed to HI/LO.
module mdu_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic [2:0]  MDUOp_E,
  input  logic        start,
  output logic [31:0] HI_E,
  output logic [31:0] LO_E,
  output logic        busy
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles < 2) ? 1 : $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     pend_hi_q;
  logic [31:0]     pend_lo_q;
  logic            pend_we_q;

  logic [63:0]     prod_s;
  logic [63:0]     prod_u;
  logic [31:0]     quo_s;
  logic [31:0]     rem_s;
  logic [31:0]     quo_u;
  logic [31:0]     rem_u;
  logic            div_zero;
  logic            accept;
  logic [63:0]     res;
  logic            res_we;
  logic [CntW-1:0] res_cnt;

  // Arithmetic datapath: every candidate result for the current operands.
  always_comb begin
    prod_s   = $signed({{32{A_E[31]}}, A_E}) * $signed({{32{B_E[31]}}, B_E});
    prod_u   = {32'd0, A_E} * {32'd0, B_E};
    div_zero = (B_E == 32'd0);
    quo_s    = '0;
    rem_s    = '0;
    quo_u    = '0;
    rem_u    = '0;
    if (!div_zero) begin
      // Most-negative / -1 overflows a 32-bit signed divide; wrap explicitly.
      if (A_E == 32'h8000_0000 && B_E == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $signed(A_E) / $signed(B_E);
        rem_s = $signed(A_E) % $signed(B_E);
      end
      quo_u = A_E / B_E;
      rem_u = A_E % B_E;
    end
  end

  // Select result, commit enable and latency for the requested operation.
  always_comb begin
    res     = '0;
    res_we  = 1'b0;
    res_cnt = CntW'(MULT_CYCLES);
    accept  = 1'b0;
    case (MDUOp_E)
      OpMult: begin
        res    = prod_s;
        res_we = 1'b1;
        accept = start;
      end
      OpMultu: begin
        res    = prod_u;
        res_we = 1'b1;
        accept = start;
      end
      OpDiv: begin
        res     = {rem_s, quo_s};
        res_we  = !div_zero;
        res_cnt = CntW'(DIV_CYCLES);
        accept  = start;
      end
      OpDivu: begin
        res     = {rem_u, quo_u};
        res_we  = !div_zero;
        res_cnt = CntW'(DIV_CYCLES);
        accept  = start;
      end
      default: ;
    endcase
  end

  // Control FSM with registered busy and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      HI_E      <= '0;
      LO_E      <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            pend_hi_q <= res[63:32];
            pend_lo_q <= res[31:0];
            pend_we_q <= res_we;
            cnt_q     <= res_cnt;
            state_q   <= StRun;
            busy      <= 1'b1;
          end else if (MDUOp_E == OpMthi) begin
            HI_E <= A_E;
          end else if (MDUOp_E == OpMtlo) begin
            LO_E <= A_E;
          end
        end
        StRun: begin
          // Inputs are deliberately ignored while running.
          if (cnt_q <= CntW'(1)) begin
            if (pend_we_q) begin
              HI_E <= pend_hi_q;
              LO_E <= pend_lo_q;
            end
            cnt_q   <= '0;
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e: randomized self-checking bench for mdu_e against an arithmetic model.
module tb_mdu_e;

  logic        clk;
  logic        reset;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic [2:0]  MDUOp_E;
  logic        start;
  logic [31:0] HI_E;
  logic [31:0] LO_E;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_e #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .A_E    (A_E),
    .B_E    (B_E),
    .MDUOp_E(MDUOp_E),
    .start  (start),
    .HI_E   (HI_E),
    .LO_E   (LO_E),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int unsigned latency(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Architectural meaning of each operation, as {HI, LO}.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa;
    longint sb;
    longint q;
    longint r;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0] v;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    v  = {hi, lo};
    case (op)
      3'd1: v = sa * sb;
      3'd2: v = ua * ub;
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        v = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 0) v = {a % b, a / b};
      3'd5: v = {a, lo};
      3'd6: v = {hi, a};
      default: ;
    endcase
    return v;
  endfunction

  // Apply one request for a single edge, then return inputs to idle.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    MDUOp_E = op;
    A_E     = a;
    B_E     = b;
    start   = st;
    @(posedge clk);
    #1;
    start   = 1'b0;
    MDUOp_E = 3'd0;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    start   = 1'b0;
    MDUOp_E = 3'd0;
    A_E     = '0;
    B_E     = '0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (HI_E !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", HI_E); end
    checks++;
    if (LO_E !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", LO_E); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
  endtask

  // Mult/div transaction: busy window, frozen HI/LO, then committed result.
  task automatic test_mul_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input bit junk);
    int unsigned n;
    logic [63:0] r;
    n = latency(op);
    r = model(op, a, b, exp_hi, exp_lo);
    drive(op, a, b, 1'b1);
    for (int i = 0; i < int'(n); i++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_window op%0d cyc%0d got %0b want 1", op, i, busy);
      end
      checks++;
      if ({HI_E, LO_E} !== {exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL hilo_frozen op%0d cyc%0d got %h_%h want %h_%h", op, i, HI_E, LO_E,
                 exp_hi, exp_lo);
      end
      if (junk) begin
        MDUOp_E = 3'($urandom_range(0, 7));
        A_E     = $urandom;
        B_E     = $urandom;
        start   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    MDUOp_E = 3'd0;
    {exp_hi, exp_lo} = r;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_end op%0d got %0b want 0", op, busy); end
    checks++;
    if ({HI_E, LO_E} !== {exp_hi, exp_lo}) begin
      errors++;
      $display("FAIL result op%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, HI_E, LO_E,
               exp_hi, exp_lo);
    end
  endtask

  task automatic test_vectors;
    test_mul_div(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    checks++;
    if ({HI_E, LO_E} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL vec_mult got %h_%h want ffffffff_fffffffe", HI_E, LO_E);
    end
    test_mul_div(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    checks++;
    if ({HI_E, LO_E} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL vec_multu got %h_%h want 00000001_fffffffe", HI_E, LO_E);
    end
    test_mul_div(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    checks++;
    if ({HI_E, LO_E} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL vec_div got %h_%h want ffffffff_fffffffd", HI_E, LO_E);
    end
    test_mul_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if ({HI_E, LO_E} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL vec_div_ovf got %h_%h want 00000000_80000000", HI_E, LO_E);
    end
  endtask

  task automatic test_div_zero;
    drive(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    drive(3'd6, 32'h1234_5678, 32'd0, 1'b0);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'h1234_5678;
    test_mul_div(3'd4, 32'd7, 32'd0, 1'b0);
    checks++;
    if ({HI_E, LO_E} !== 64'h1234_5678_1234_5678) begin
      errors++; $display("FAIL divu_zero got %h_%h want 12345678_12345678", HI_E, LO_E);
    end
    test_mul_div(3'd3, 32'hDEAD_0001, 32'd0, 1'b0);
  endtask

  task automatic test_move;
    drive(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
    checks++;
    if (HI_E !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got %h want deadbeef", HI_E); end
    checks++;
    if (LO_E !== exp_lo) begin errors++; $display("FAIL mthi_lo got %h want %h", LO_E, exp_lo); end
    exp_hi = 32'hDEAD_BEEF;
    drive(3'd6, 32'h0BAD_F00D, 32'd0, 1'b0);
    checks++;
    if ({HI_E, LO_E, busy} !== {exp_hi, 32'h0BAD_F00D, 1'b0}) begin
      errors++; $display("FAIL mtlo got %h_%h busy %0b want %h_0badf00d busy 0", HI_E, LO_E, busy,
                         exp_hi);
    end
    exp_lo = 32'h0BAD_F00D;
  endtask

  task automatic test_overlap;
    drive(3'd1, 32'd3, 32'd4, 1'b1);   // busy cycle 1 follows
    @(posedge clk);
    #1;                                 // busy cycle 2
    drive(3'd4, 32'd9, 32'd2, 1'b1);
    drive(3'd6, 32'h0000_AAAA, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL overlap_busy cyc%0d got %0b want 1", i + 4, busy); end
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL overlap_end got %0b want 0", busy); end
    checks++;
    if ({HI_E, LO_E} !== 64'h0000_0000_0000_000C) begin
      errors++; $display("FAIL overlap_result got %h_%h want 00000000_0000000c", HI_E, LO_E);
    end
    exp_hi = 32'd0;
    exp_lo = 32'h0000_000C;
    // The ignored divu must not have left anything in flight.
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if ({HI_E, LO_E, busy} !== {exp_hi, exp_lo, 1'b0}) begin
      errors++; $display("FAIL overlap_late got %h_%h busy %0b want %h_%h busy 0", HI_E, LO_E,
                         busy, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid;
    drive(3'd5, 32'h5555_0000, 32'd0, 1'b0);
    drive(3'd6, 32'h0000_5555, 32'd0, 1'b0);
    drive(3'd3, 32'd100, 32'd7, 1'b1);  // busy cycle 1
    repeat (3) @(posedge clk);
    #1;                                 // busy cycle 4
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({HI_E, LO_E, busy} !== 65'd0) begin
      errors++; $display("FAIL reset_mid got %h_%h busy %0b want 0_0 busy 0", HI_E, LO_E, busy);
    end
    @(negedge clk);
    reset  = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({HI_E, LO_E, busy} !== 65'd0) begin
        errors++; $display("FAIL reset_late cyc%0d got %h_%h busy %0b want 0_0 busy 0", i, HI_E,
                           LO_E, busy);
      end
    end
    test_mul_div(3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        st;
    for (int it = 0; it < 80; it++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (it % 11 == 0) a = 32'h8000_0000;
      if (op >= 3'd1 && op <= 3'd4) begin
        test_mul_div(op, a, b, 1'b1);
      end else begin
        st = 1'($urandom_range(0, 1));
        {exp_hi, exp_lo} = model(op, a, b, exp_hi, exp_lo);
        drive(op, a, b, st);
        checks++;
        if ({HI_E, LO_E, busy} !== {exp_hi, exp_lo, 1'b0}) begin
          errors++; $display("FAIL rand_idle op%0d st%0b got %h_%h busy %0b want %h_%h busy 0",
                             op, st, HI_E, LO_E, busy, exp_hi, exp_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_div_zero;
    test_move;
    test_overlap;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
